// File: rtl/hamming74_serial_encoder_pkg.sv
// Shared definitions for the Hamming(7,4) serial link: codeword bit layout,
// encoder FSM states and the nibble-to-codeword function.
package hamming74_serial_encoder_pkg;

   // Position of each data/parity bit inside the 7-bit codeword
   localparam int C_D0 = 0;
   localparam int C_D1 = 1;
   localparam int C_D2 = 2;
   localparam int C_P3 = 3;
   localparam int C_D3 = 4;
   localparam int C_P5 = 5;
   localparam int C_P6 = 6;

   typedef enum logic [1:0] {IDLE, SEND, SLOT} state_e;

   function automatic logic [6:0] hamming74_encode(input logic [3:0] d);
      logic [6:0] c;
      c       = '0;
      c[C_D0] = d[0];
      c[C_D1] = d[1];
      c[C_D2] = d[2];
      c[C_P3] = d[2] ^ d[1] ^ d[0];
      c[C_D3] = d[3];
      c[C_P5] = d[3] ^ d[1] ^ d[0];
      c[C_P6] = d[3] ^ d[2] ^ d[0];
      return c;
   endfunction

endpackage

// File: rtl/hamming74_serial_encoder_if.sv
// Nibble handshake plus serial frame outputs of the Hamming(7,4) encoder.
interface hamming74_serial_encoder_if;
   logic [3:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic       encode_out;
   logic       frame_ena;
   logic       frame_start;
   logic       busy;

   modport master (
      output data_in, data_valid,
      input  data_ready, encode_out, frame_ena, frame_start, busy
   );

   modport slave (
      input  data_in, data_valid,
      output data_ready, encode_out, frame_ena, frame_start, busy
   );
endinterface

// File: rtl/hamming74_hold_reg.sv
// One-entry holding register that parks a nibble accepted while a frame is
// still on the wire. A write and an unload in the same cycle keep it full
// with the new nibble.
module hamming74_hold_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       wr_valid,
   input  logic [3:0] wr_data,
   output logic       wr_ready,
   input  logic       rd_en,
   output logic       rd_valid,
   output logic [3:0] rd_data
);

   logic       full_q, full_d;
   logic [3:0] data_q, data_d;

   // next occupancy and contents; everything freezes while ena is low
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (ena) begin
         if (rd_en) full_d = 1'b0;
         if (wr_valid) begin
            full_d = 1'b1;
            data_d = wr_data;
         end
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign wr_ready = !full_q;
   assign rd_valid = full_q;
   assign rd_data  = data_q;

endmodule

// File: rtl/hamming74_serial_encoder.sv
// Serial Hamming(7,4) encoder: accepts nibbles, shifts out c0..c6 LSB first,
// then SLOT_CYCLES idle-level cycles with frame_ena high so the downstream
// decoder gets its decode slot. Frames chain back to back via the hold reg.
module hamming74_serial_encoder #(
   parameter int SLOT_CYCLES = 1,     // 1..4, slot counter is 2 bits wide
   parameter bit IDLE_BIT    = 1'b0
) (
   input logic                        clk,
   input logic                        rst,
   input logic                        ena,
   hamming74_serial_encoder_if.slave  bus
);
   import hamming74_serial_encoder_pkg::*;

   localparam logic [1:0] SLOT_LAST = 2'(SLOT_CYCLES - 1);

   state_e     state_q,       state_d;
   logic [2:0] bit_cnt_q,     bit_cnt_d;
   logic [1:0] slot_cnt_q,    slot_cnt_d;
   logic [6:0] code_q,        code_d;
   logic       encode_out_q,  encode_out_d;
   logic       frame_ena_q,   frame_ena_d;
   logic       frame_start_q, frame_start_d;

   logic       hold_ready, hold_full;
   logic [3:0] hold_data;
   logic       accept, last_slot, bypass, hold_wr, hold_rd;
   logic       start_new;
   logic [3:0] start_nibble;

   assign bus.data_ready = ena && hold_ready;
   assign accept         = bus.data_valid && bus.data_ready;
   assign last_slot      = (state_q == SLOT) && (slot_cnt_q == SLOT_LAST);
   // a new nibble goes straight to the shifter when a frame can start now
   // and nothing is already waiting in the hold register
   assign bypass         = (state_q == IDLE) || (last_slot && !hold_full);
   assign hold_wr        = accept && !bypass;
   assign hold_rd        = ena && last_slot && hold_full;

   hamming74_hold_reg u_hold (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .wr_valid (hold_wr),
      .wr_data  (bus.data_in),
      .wr_ready (hold_ready),
      .rd_en    (hold_rd),
      .rd_valid (hold_full),
      .rd_data  (hold_data)
   );

   // frame sequencing: next state, bit/slot counters and registered outputs
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      slot_cnt_d    = slot_cnt_q;
      code_d        = code_q;
      encode_out_d  = encode_out_q;
      frame_ena_d   = frame_ena_q;
      frame_start_d = frame_start_q;
      start_new     = 1'b0;
      start_nibble  = hold_data;
      if (ena) begin
         frame_start_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  start_new    = 1'b1;
                  start_nibble = bus.data_in;
               end
            end
            SEND: begin
               if (bit_cnt_q == 3'd6) begin
                  state_d      = SLOT;
                  slot_cnt_d   = '0;
                  encode_out_d = IDLE_BIT;
                  frame_ena_d  = 1'b1;
               end else begin
                  bit_cnt_d    = bit_cnt_q + 3'd1;
                  encode_out_d = code_q[bit_cnt_q + 3'd1];
               end
            end
            SLOT: begin
               if (slot_cnt_q == SLOT_LAST) begin
                  if (hold_full) begin
                     start_new    = 1'b1;
                     start_nibble = hold_data;
                  end else if (accept) begin
                     start_new    = 1'b1;
                     start_nibble = bus.data_in;
                  end else begin
                     state_d      = IDLE;
                     encode_out_d = IDLE_BIT;
                     frame_ena_d  = 1'b0;
                  end
               end else begin
                  slot_cnt_d = slot_cnt_q + 2'd1;
               end
            end
            default: state_d = IDLE;
         endcase
         // the codeword is latched here so later data_in changes are ignored
         if (start_new) begin
            code_d        = hamming74_encode(start_nibble);
            state_d       = SEND;
            bit_cnt_d     = '0;
            encode_out_d  = code_d[C_D0];
            frame_ena_d   = 1'b1;
            frame_start_d = 1'b1;
         end
      end
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         slot_cnt_q    <= '0;
         code_q        <= '0;
         encode_out_q  <= IDLE_BIT;
         frame_ena_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         slot_cnt_q    <= slot_cnt_d;
         code_q        <= code_d;
         encode_out_q  <= encode_out_d;
         frame_ena_q   <= frame_ena_d;
         frame_start_q <= frame_start_d;
      end
   end

   // strobes drop in any cycle with ena low so the decoder does not count it
   assign bus.encode_out  = encode_out_q;
   assign bus.frame_ena   = frame_ena_q && ena;
   assign bus.frame_start = frame_start_q && ena;
   assign bus.busy        = (state_q != IDLE) || hold_full;

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Bench for the serial Hamming(7,4) encoder. Two instances (SLOT_CYCLES=1,
// IDLE_BIT=0 and SLOT_CYCLES=3, IDLE_BIT=1) share stimulus; each is compared
// every cycle against an expected-output stream built from accepted nibbles.
// Instance 0 also feeds a loopback decoder that recovers each nibble.
module tb_hamming74_serial_encoder;

   localparam int S0 = 1;
   localparam int S1 = 3;
   localparam bit I0 = 1'b0;
   localparam bit I1 = 1'b1;

   typedef logic [2:0] item_t;   // {frame_start, frame_ena, encode_out}
   localparam item_t IDLE0 = {2'b00, I0};
   localparam item_t IDLE1 = {2'b00, I1};

   logic       clk = 1'b0;
   logic       rst, ena, dv;
   logic [3:0] din;

   int checks = 0;
   int errors = 0;

   item_t      q0[$], q1[$];
   item_t      cur0 = IDLE0, cur1 = IDLE1;
   logic [3:0] dq0[$];
   logic [6:0] lb_sr = '0, last_cw = '0;
   logic [3:0] lb_cnt = '0;
   int         run0 = 0, run1 = 0, max0 = 0, max1 = 0;

   always #5 clk = ~clk;

   hamming74_serial_encoder_if if0 ();
   hamming74_serial_encoder_if if1 ();

   assign if0.data_in    = din;
   assign if0.data_valid = dv;
   assign if1.data_in    = din;
   assign if1.data_valid = dv;

   hamming74_serial_encoder #(.SLOT_CYCLES(S0), .IDLE_BIT(I0)) u0 (
      .clk (clk), .rst (rst), .ena (ena), .bus (if0)
   );
   hamming74_serial_encoder #(.SLOT_CYCLES(S1), .IDLE_BIT(I1)) u1 (
      .clk (clk), .rst (rst), .ena (ena), .bus (if1)
   );

   // codeword from the parity equations: parity bits are XOR over masked data
   function automatic logic [6:0] ref_code(input logic [3:0] n);
      return {^(n & 4'b1101), ^(n & 4'b1011), n[3], ^(n & 4'b0111), n[2], n[1], n[0]};
   endfunction

   // nearest-codeword decode: the nibble whose codeword is within distance 1
   function automatic logic [3:0] ref_decode(input logic [6:0] r);
      logic [3:0] res;
      res = '0;
      for (int n = 0; n < 16; n++)
         if ($countones(ref_code(4'(n)) ^ r) <= 1) res = 4'(n);
      return res;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push0(input logic [3:0] n);
      logic [6:0] c;
      c = ref_code(n);
      for (int i = 0; i < 7; i++) q0.push_back({(i == 0), 1'b1, c[i]});
      for (int i = 0; i < S0; i++) q0.push_back({2'b01, I0});
   endtask

   task automatic push1(input logic [3:0] n);
      logic [6:0] c;
      c = ref_code(n);
      for (int i = 0; i < 7; i++) q1.push_back({(i == 0), 1'b1, c[i]});
      for (int i = 0; i < S1; i++) q1.push_back({2'b01, I1});
   endtask

   // one clock: drive at negedge, check shortly after, update model at posedge
   task automatic step(input logic r, input logic e, input logic v, input logic [3:0] d);
      logic full0, full1, rdy0, rdy1;
      rst = r; ena = e; dv = v; din = d;
      #1;
      full0 = (q0.size() >= 7 + S0);
      full1 = (q1.size() >= 7 + S1);
      rdy0  = e && !full0;
      rdy1  = e && !full1;
      if (!r) begin
         chk("ready0", if0.data_ready,  rdy0);
         chk("eout0",  if0.encode_out,  cur0[0]);
         chk("fena0",  if0.frame_ena,   cur0[1] & e);
         chk("fstrt0", if0.frame_start, cur0[2] & e);
         chk("busy0",  if0.busy,        cur0[1] | full0);
         chk("ready1", if1.data_ready,  rdy1);
         chk("eout1",  if1.encode_out,  cur1[0]);
         chk("fena1",  if1.frame_ena,   cur1[1] & e);
         chk("fstrt1", if1.frame_start, cur1[2] & e);
         chk("busy1",  if1.busy,        cur1[1] | full1);
         if (if0.frame_ena) run0++;
         else begin
            if (run0 > max0) max0 = run0;
            run0 = 0;
         end
         if (if1.frame_ena) run1++;
         else begin
            if (run1 > max1) max1 = run1;
            run1 = 0;
         end
         // loopback decoder with an 8-count frame cycle
         if (if0.frame_ena) begin
            if (lb_cnt < 4'd7) lb_sr[lb_cnt[2:0]] = if0.encode_out;
            lb_cnt++;
            if (lb_cnt == 4'd8) begin
               lb_cnt  = '0;
               last_cw = lb_sr;
               chk("lb_pending", (dq0.size() != 0), 1'b1);
               if (dq0.size() != 0) chkv("lb_decode", ref_decode(lb_sr), dq0.pop_front());
            end
         end
      end
      @(posedge clk);
      if (r) begin
         q0.delete(); q1.delete(); dq0.delete();
         cur0 = IDLE0; cur1 = IDLE1; lb_cnt = '0;
      end else if (e) begin
         if (v && rdy0) begin push0(d); dq0.push_back(d); end
         if (v && rdy1) push1(d);
         cur0 = (q0.size() != 0) ? q0.pop_front() : IDLE0;
         cur1 = (q1.size() != 0) ? q1.pop_front() : IDLE1;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 4'($urandom));
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; dv = 1'b0; din = '0;
      @(negedge clk);
      step(1'b1, 1'b1, 1'b0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 4'h0);
      idle(2);                                   // reset values

      // single frame 4'b1011 -> 7'h33
      step(1'b0, 1'b1, 1'b1, 4'b1011);
      idle(12);
      chkv("cw_1011", last_cw, 7'h33);

      // known vectors
      step(1'b0, 1'b1, 1'b1, 4'h0); idle(12); chkv("cw_0000", last_cw, 7'h00);
      step(1'b0, 1'b1, 1'b1, 4'hF); idle(12); chkv("cw_1111", last_cw, 7'h7F);
      step(1'b0, 1'b1, 1'b1, 4'h1); idle(12); chkv("cw_0001", last_cw, 7'h69);

      // all nibbles in loopback
      for (int n = 0; n < 16; n++) begin
         step(1'b0, 1'b1, 1'b1, 4'(n));
         idle(12);
      end

      // back-to-back frames through the hold register
      max0 = 0; max1 = 0;
      step(1'b0, 1'b1, 1'b1, 4'h5);
      step(1'b0, 1'b1, 1'b1, 4'hA);
      idle(24);
      chkv("b2b_run0", max0, 16);
      chkv("b2b_run1", max1, 20);

      // ena low for 3 cycles mid-frame
      step(1'b0, 1'b1, 1'b1, 4'b1011);
      idle(4);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'($urandom));
      idle(12);
      chkv("cw_ena_gap", last_cw, 7'h33);

      // randomized traffic with random ena
      for (int i = 0; i < 300; i++)
         step(1'b0, ($urandom_range(0, 6) != 0), $urandom_range(0, 1) == 1, 4'($urandom));
      idle(30);

      // reset at c2 with the hold register full
      step(1'b0, 1'b1, 1'b1, 4'h6);
      step(1'b0, 1'b1, 1'b1, 4'h3);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      step(1'b1, 1'b1, 1'b0, 4'h0);
      idle(2);                                   // clean reset values
      step(1'b0, 1'b1, 1'b1, 4'h9);
      idle(12);
      chkv("cw_after_rst", last_cw, 7'h19);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
